// File: rtl/uart_pkg.sv
// Shared types for the UART transmit arbiter: FSM states and byte/requester sizing.
// Pure declarations; no latency or flow-control behaviour of its own.
package uart_pkg;
  localparam int BYTE_W  = 8;
  localparam int NUM_REQ = 2;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_START,
    ST_WAIT_DONE,
    ST_GAP
  } state_t;
endpackage

// File: rtl/rr_arbiter2.sv
// Combinational 2-way round-robin pick; ptr names the requester served last.
// Zero latency; a lone valid always wins, a tie goes to the requester opposite ptr.
module rr_arbiter2
  import uart_pkg::*;
(
  input  logic [NUM_REQ-1:0] valid,
  input  logic               ptr,
  output logic [NUM_REQ-1:0] grant
);

  always_comb begin
    grant = valid;
    if (valid == 2'b11) begin
      grant = ptr ? 2'b01 : 2'b10;
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares one UART transmitter between two byte streams, locking the grant per message.
// IDLE->tx_start 3 cycles, done->next start GAP_CYCLES+2; requesters wait in FETCH while enable is low.
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int GAP_CYCLES     = 0,
  parameter int TIMEOUT_CYCLES = 4096,
  parameter int TW             = 13
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              enable,
  input  logic              req0_valid,
  input  logic [BYTE_W-1:0] req0_data,
  input  logic              req0_last,
  output logic              req0_ready,
  input  logic              req1_valid,
  input  logic [BYTE_W-1:0] req1_data,
  input  logic              req1_last,
  output logic              req1_ready,
  output logic              tx_enable,
  output logic              tx_start,
  output logic [BYTE_W-1:0] tx_data,
  input  logic              tx_busy,
  input  logic              tx_done,
  output logic [NUM_REQ-1:0] grant,
  output logic              idle,
  output logic              timeout_err
);

  state_t               state, state_n;
  state_t               target, target_n;
  logic [TW-1:0]        cnt, cnt_n;
  logic [BYTE_W-1:0]    data_r, data_n;
  logic                 last_r, last_n;
  logic [NUM_REQ-1:0]   grant_r, grant_n;
  logic                 ptr, ptr_n;
  logic                 terr, terr_n;
  logic [NUM_REQ-1:0]   pick;
  logic                 sel_valid;
  logic                 sel_last;
  logic [BYTE_W-1:0]    sel_data;

  rr_arbiter2 u_rr (
    .valid ({req1_valid, req0_valid}),
    .ptr   (ptr),
    .grant (pick)
  );

  // Only the locked owner's stream is ever looked at once a grant exists.
  assign sel_valid = grant_r[1] ? req1_valid : req0_valid;
  assign sel_last  = grant_r[1] ? req1_last  : req0_last;
  assign sel_data  = grant_r[1] ? req1_data  : req0_data;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ST_IDLE;
      target  <= ST_IDLE;
      cnt     <= '0;
      data_r  <= '0;
      last_r  <= 1'b0;
      grant_r <= '0;
      ptr     <= 1'b1;
      terr    <= 1'b0;
    end else begin
      state   <= state_n;
      target  <= target_n;
      cnt     <= cnt_n;
      data_r  <= data_n;
      last_r  <= last_n;
      grant_r <= grant_n;
      ptr     <= ptr_n;
      terr    <= terr_n;
    end
  end

  always_comb begin
    state_n    = state;
    target_n   = target;
    cnt_n      = cnt;
    data_n     = data_r;
    last_n     = last_r;
    grant_n    = grant_r;
    ptr_n      = ptr;
    terr_n     = terr;
    tx_start   = 1'b0;
    req0_ready = 1'b0;
    req1_ready = 1'b0;

    case (state)
      ST_IDLE: begin
        if (enable && (req0_valid || req1_valid)) begin
          grant_n = pick;
          state_n = ST_FETCH;
        end
      end
      ST_FETCH: begin
        if (enable) begin
          req0_ready = grant_r[0];
          req1_ready = grant_r[1];
          if (sel_valid) begin
            data_n  = sel_data;
            last_n  = sel_last;
            state_n = ST_START;
          end
        end
      end
      ST_START: begin
        if (!tx_busy) begin
          tx_start = 1'b1;
          cnt_n    = '0;
          state_n  = ST_WAIT_DONE;
        end
      end
      ST_WAIT_DONE: begin
        // done is checked first so a done landing on the final watchdog cycle still counts
        if (tx_done) begin
          cnt_n = '0;
          if (last_r) begin
            grant_n  = '0;
            ptr_n    = grant_r[1];
            target_n = ST_IDLE;
          end else begin
            target_n = ST_FETCH;
          end
          if (GAP_CYCLES != 0) begin
            state_n = ST_GAP;
          end else begin
            state_n = last_r ? ST_IDLE : ST_FETCH;
          end
        end else if (cnt == TW'(TIMEOUT_CYCLES - 1)) begin
          terr_n  = 1'b1;
          grant_n = '0;
          ptr_n   = grant_r[1];
          cnt_n   = '0;
          state_n = ST_IDLE;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      ST_GAP: begin
        if (cnt == TW'(GAP_CYCLES - 1)) begin
          cnt_n   = '0;
          state_n = target;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      default: begin
        state_n = ST_IDLE;
      end
    endcase
  end

  assign tx_enable   = enable;
  assign tx_data     = data_r;
  assign grant       = grant_r;
  assign idle        = (state == ST_IDLE);
  assign timeout_err = terr;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter with a behavioural transmitter and a start-time scoreboard.
module tb_uart_tx_arbiter;

  typedef struct packed {
    logic [7:0] data;
    logic [1:0] gnt;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       enable;
  logic       req0_valid, req0_last, req0_ready;
  logic [7:0] req0_data;
  logic       req1_valid, req1_last, req1_ready;
  logic [7:0] req1_data;
  logic       tx_enable, tx_start, tx_busy, tx_done;
  logic [7:0] tx_data;
  logic [1:0] grant;
  logic       idle, timeout_err;

  int   tests = 0;
  int   fails = 0;
  int   cyc = 0;
  int   dly = 10;
  bit   mute = 1'b0;
  bit   pend = 1'b0;
  int   bcnt = 0;
  logic [7:0] cur_byte = 8'h00;
  int   start_log[$];
  int   done_log[$];
  exp_t exp_q[$];
  int   r0_rdy_cnt = 0;
  int   r1_lock_rdy = 0;
  bit   lock_phase = 1'b0;
  int   last_vcyc = 0;

  always #5 clk = ~clk;

  uart_tx_arbiter #(
    .GAP_CYCLES     (5),
    .TIMEOUT_CYCLES (16),
    .TW             (13)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .enable      (enable),
    .req0_valid  (req0_valid),
    .req0_data   (req0_data),
    .req0_last   (req0_last),
    .req0_ready  (req0_ready),
    .req1_valid  (req1_valid),
    .req1_data   (req1_data),
    .req1_last   (req1_last),
    .req1_ready  (req1_ready),
    .tx_enable   (tx_enable),
    .tx_start    (tx_start),
    .tx_data     (tx_data),
    .tx_busy     (tx_busy),
    .tx_done     (tx_done),
    .grant       (grant),
    .idle        (idle),
    .timeout_err (timeout_err)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic bound_fail(input string name);
    tests++;
    fails++;
    $display("FAIL %s: wait bound expired", name);
  endtask

  task automatic expect_byte(input logic [7:0] d, input logic [1:0] g);
    exp_t e;
    e.data = d;
    e.gnt  = g;
    exp_q.push_back(e);
  endtask

  // Transmitter model: busy from the cycle after the start is taken, done after dly cycles.
  initial begin
    logic st;
    logic b0;
    tx_busy = 1'b0;
    tx_done = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      if (!rst_n) begin
        tx_busy = 1'b0;
        tx_done = 1'b0;
        pend    = 1'b0;
        continue;
      end
      st = tx_start;
      b0 = tx_busy;
      tx_done = 1'b0;
      if (pend) begin
        pend    = 1'b0;
        tx_busy = 1'b1;
        bcnt    = 0;
      end else if (tx_busy) begin
        bcnt++;
        if (bcnt == dly) begin
          tx_busy = 1'b0;
          if (!mute) begin
            tx_done = 1'b1;
            done_log.push_back(cyc);
            chk("tx_data_held", tx_data, cur_byte);
          end
        end
      end
      if (st) begin
        chk("start_while_busy", b0, 1'b0);
        pend     = 1'b1;
        cur_byte = tx_data;
        start_log.push_back(cyc);
      end
    end
  end

  // Scoreboard monitor: every start pops the next expected byte and owner.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #2;
      if (rst_n && tx_start) begin
        if (exp_q.size() == 0) begin
          bound_fail("unexpected_tx_start");
        end else begin
          e = exp_q.pop_front();
          chk("sb_tx_data", tx_data, e.data);
          chk("sb_grant", grant, e.gnt);
        end
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (req0_ready) r0_rdy_cnt++;
      if (lock_phase && req1_ready) r1_lock_rdy++;
    end
  end

  task automatic send(input int r, input logic [7:0] d, input logic l);
    int   n;
    logic rdy;
    @(negedge clk);
    if (r == 0) begin
      req0_valid = 1'b1; req0_data = d; req0_last = l;
    end else begin
      req1_valid = 1'b1; req1_data = d; req1_last = l;
    end
    last_vcyc = cyc;
    n = 0;
    rdy = (r == 0) ? req0_ready : req1_ready;
    while (!rdy && n < 300) begin
      @(negedge clk);
      n++;
      rdy = (r == 0) ? req0_ready : req1_ready;
    end
    if (!rdy) bound_fail($sformatf("handshake_req%0d", r));
    else @(posedge clk);
    #1;
    if (r == 0) req0_valid = 1'b0;
    else        req1_valid = 1'b0;
  endtask

  task automatic wait_quiet(input string name);
    int n;
    n = 0;
    while (!(idle && !tx_busy && !pend && exp_q.size() == 0) && n < 600) begin
      @(negedge clk);
      n++;
    end
    if (n >= 600) bound_fail(name);
  endtask

  task automatic wait_start(input string name);
    int n;
    n = 0;
    while (start_log.size() == 0 && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (start_log.size() == 0) bound_fail(name);
  endtask

  initial begin
    #500000;
    $display("FAIL global_watchdog: simulation did not finish");
    $fatal(1, "global watchdog");
  end

  initial begin
    int v;
    int n;
    int ecyc;
    rst_n = 1'b0; enable = 1'b1;
    req0_valid = 1'b0; req0_data = 8'h00; req0_last = 1'b0;
    req1_valid = 1'b0; req1_data = 8'h00; req1_last = 1'b0;
    #12;
    chk("rst_idle", idle, 1'b1);
    chk("rst_grant", grant, 2'b00);
    chk("rst_tx_start", tx_start, 1'b0);
    chk("rst_tx_data", tx_data, 8'h00);
    chk("rst_timeout_err", timeout_err, 1'b0);
    chk("rst_ready", {req1_ready, req0_ready}, 2'b00);
    chk("tx_enable_follow", tx_enable, 1'b1);
    @(negedge clk);
    rst_n = 1'b1;

    // first tie after reset goes to requester 0, then requester 1
    expect_byte(8'h65, 2'b01);
    expect_byte(8'h6C, 2'b10);
    fork
      send(0, 8'h65, 1'b1);
      send(1, 8'h6C, 1'b1);
    join
    wait_quiet("tie1");
    expect_byte(8'h41, 2'b01);
    expect_byte(8'h42, 2'b10);
    fork
      send(0, 8'h41, 1'b1);
      send(1, 8'h42, 1'b1);
    join
    wait_quiet("tie2");

    // single byte, latency and ready width
    r0_rdy_cnt = 0; start_log.delete(); done_log.delete();
    expect_byte(8'h68, 2'b01);
    send(0, 8'h68, 1'b1);
    v = last_vcyc;
    wait_quiet("single");
    chk("single_ready_cycles", r0_rdy_cnt, 1);
    chk("single_start_count", start_log.size(), 1);
    chk("single_latency", start_log[0] - v, 2);
    chk("single_done_count", done_log.size(), 1);
    chk("single_grant_after", grant, 2'b00);
    chk("single_idle_after", idle, 1'b1);

    // requester 0 served last, so a tie now goes to requester 1
    expect_byte(8'hB1, 2'b10);
    expect_byte(8'hB0, 2'b01);
    fork
      send(0, 8'hB0, 1'b1);
      send(1, 8'hB1, 1'b1);
    join
    wait_quiet("tie3");

    // message lock: req1 waits for all three req0 bytes
    r1_lock_rdy = 0; lock_phase = 1'b1;
    expect_byte(8'h68, 2'b01);
    expect_byte(8'h65, 2'b01);
    expect_byte(8'h6C, 2'b01);
    expect_byte(8'h77, 2'b10);
    fork
      begin
        send(0, 8'h68, 1'b0);
        send(0, 8'h65, 1'b0);
        send(0, 8'h6C, 1'b1);
        lock_phase = 1'b0;
      end
      begin
        @(negedge clk);
        send(1, 8'h77, 1'b1);
      end
    join
    wait_quiet("lock");
    chk("lock_req1_ready_early", r1_lock_rdy, 0);

    // inter-byte gap inside a message
    start_log.delete(); done_log.delete();
    expect_byte(8'hA1, 2'b10);
    expect_byte(8'hA2, 2'b10);
    send(1, 8'hA1, 1'b0);
    send(1, 8'hA2, 1'b1);
    wait_quiet("gap");
    chk("gap_start_count", start_log.size(), 2);
    chk("gap_done_to_start", start_log[1] - done_log[0], 7);

    // done on the last watchdog cycle wins over the timeout
    dly = 15;
    done_log.delete();
    expect_byte(8'hC3, 2'b01);
    send(0, 8'hC3, 1'b1);
    wait_quiet("coincide");
    chk("coincide_done_seen", done_log.size(), 1);
    chk("coincide_no_err", timeout_err, 1'b0);
    dly = 10;

    // enable dropped mid-byte
    start_log.delete(); done_log.delete();
    expect_byte(8'h31, 2'b01);
    expect_byte(8'h32, 2'b01);
    fork
      begin
        send(0, 8'h31, 1'b0);
        send(0, 8'h32, 1'b1);
      end
      begin
        wait_start("en_first_start");
        @(posedge clk);
        #1 enable = 1'b0;
        repeat (40) @(posedge clk);
        #3;
        chk("en_off_tx_enable", tx_enable, 1'b0);
        chk("en_off_starts", start_log.size(), 1);
        chk("en_off_done", done_log.size(), 1);
        chk("en_off_ready", req0_ready, 1'b0);
        chk("en_off_grant_held", grant, 2'b01);
        enable = 1'b1;
      end
    join
    wait_quiet("enable");
    chk("en_on_starts", start_log.size(), 2);

    // watchdog expiry
    start_log.delete(); done_log.delete();
    mute = 1'b1;
    expect_byte(8'h54, 2'b01);
    send(0, 8'h54, 1'b1);
    n = 0;
    while (!timeout_err && n < 100) begin
      @(posedge clk);
      #3;
      n++;
    end
    ecyc = cyc;
    if (!timeout_err) bound_fail("timeout_wait");
    chk("timeout_cycle", ecyc - start_log[0], 17);
    chk("timeout_grant", grant, 2'b00);
    chk("timeout_idle", idle, 1'b1);
    mute = 1'b0;
    wait_quiet("timeout_drain");
    expect_byte(8'h55, 2'b01);
    send(0, 8'h55, 1'b1);
    wait_quiet("after_timeout");
    chk("timeout_sticky", timeout_err, 1'b1);

    // reset in the middle of WAIT_DONE
    start_log.delete(); done_log.delete();
    expect_byte(8'h99, 2'b01);
    send(0, 8'h99, 1'b1);
    wait_start("reset_start");
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_tx_start", tx_start, 1'b0);
    chk("arst_grant", grant, 2'b00);
    chk("arst_idle", idle, 1'b1);
    chk("arst_tx_data", tx_data, 8'h00);
    chk("arst_timeout_err", timeout_err, 1'b0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    done_log.delete();
    expect_byte(8'h64, 2'b01);
    send(0, 8'h64, 1'b1);
    wait_quiet("post_reset");
    chk("post_reset_done", done_log.size(), 1);
    chk("post_reset_no_err", timeout_err, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
- Shares one uart_transmitter between two byte-stream requesters (e.g. status printer and debug echo).
- Arbitrates round-robin per message. A grant stays locked until the requester's byte flagged last has been fully transmitted.
- Drives the transmitter's start/in handshake and waits for its done pulse before issuing the next byte.
- Provides a done-timeout watchdog and a configurable inter-byte gap.

Parameters:
- GAP_CYCLES, 0, idle clk cycles inserted after each tx_done before the next fetch or arbitration.
- TIMEOUT_CYCLES, 4096, max clk cycles in WAIT_DONE before the byte is abandoned. Must be ≥ 1.
- TW, 13, width of the shared gap/timeout counter. Must satisfy 2^TW > max(GAP_CYCLES, TIMEOUT_CYCLES).

Ports:
- clk  in  1  system clock, all logic on rising edge
- rst_n  in  1  asynchronous active-low reset
- enable  in  1  global enable, forwarded to transmitter
- req0_valid  in  1  requester 0 has a byte
- req0_data  in  8  requester 0 byte
- req0_last  in  1  byte ends requester 0 message
- req0_ready  out  1  requester 0 byte accepted this cycle when valid&ready
- req1_valid, req1_data[8], req1_last, req1_ready: same as requester 0, for requester 1
- tx_enable  out  1  = enable
- tx_start  out  1  one-cycle start pulse to transmitter
- tx_data  out  8  byte to transmitter, held stable from start through done
- tx_busy  in  1  transmitter busy
- tx_done  in  1  one-cycle pulse, stop bit finished
- grant  out  2  one-hot current owner, 00 when unlocked
- idle  out  1  state==IDLE
- timeout_err  out  1  sticky, set on watchdog expiry, cleared only by reset

Behaviour:
- Reset values:
  - All outputs 0 except idle=1.
  - State IDLE, counter 0, tx_data 0.
  - RR pointer = "last served 1", so requester 0 wins the first tie.
- State machine. All outputs are registered or decoded from registered state; no combinational path from req*_valid to req*_ready.
- IDLE:
  - If enable and any reqX_valid, grant the requester not served last (tie → opposite of pointer).
  - If only one is valid, grant that one.
  - grant is set next cycle; go FETCH.
- FETCH:
  - reqX_ready=1 for the granted requester only.
  - On valid&ready: latch data→tx_data and last→last_r; go START.
  - If valid is low, stay; the lock is held indefinitely.
  - If enable is low, ready=0 and stay.
- START:
  - If !tx_busy, assert tx_start for exactly 1 cycle, clear counter, go WAIT_DONE.
  - If tx_busy, wait.
- WAIT_DONE:
  - On tx_done: go GAP, or skip GAP if GAP_CYCLES=0.
    - If last_r: clear grant, pointer ← granted index, target=IDLE.
    - Else: target=FETCH.
  - Counter increments each cycle. On counter==TIMEOUT_CYCLES-1 without done:
    - set timeout_err
    - clear grant, update pointer
    - go IDLE
    - the remainder of the message is abandoned; subsequent bytes from that requester start a new arbitration.
- GAP: count GAP_CYCLES cycles, then go to target.
- Latency:
  - IDLE→tx_start is 3 cycles minimum (IDLE, FETCH, START) with valid already high and tx_busy low.
  - tx_done→next tx_start is GAP_CYCLES+2 cycles within a locked message.
- Boundary conditions:
  - tx_done and timeout in the same cycle: done wins; no error.
  - enable dropped mid-byte: current byte completes through WAIT_DONE/GAP; no new FETCH transfer until enable returns.
  - Requester drops valid in FETCH: no transfer, no timeout (the watchdog runs only in WAIT_DONE).
  - rst_n low at any time: immediate return to reset values; tx_start forced 0 asynchronously.
  - tx_done outside WAIT_DONE is ignored.
  - The arbiter never issues tx_start while tx_busy=1.

Decomposition:
- Package uart_pkg:
  - state encoding localparams (ST_IDLE, ST_FETCH, ST_START, ST_WAIT_DONE, ST_GAP)
  - BYTE_W=8
  - NUM_REQ=2
- One natural sub-module: rr_arbiter2. Pure combinational 2-way round-robin pick from valids + pointer, returns one-hot grant.
- Counter and FSM stay in the top.

Test Plan:
- Single byte: req0_valid, data 0x68, last=1; model tx_done 20 cycles after start → tx_start once with tx_data=0x68, req0_ready 1 cycle, grant 01→00, idle=1 after done.
- Simultaneous requests, single-byte messages: req0 0x65, req1 0x6C, both valid after reset → req0 served first, then req1; grants 01 then 10; next tie goes to req0.
- Lock: req0 sends 0x68,0x65,0x6C (last on 0x6C) while req1 holds 0x77 valid → all three req0 bytes are transmitted before req1_ready ever rises; then 0x77 is sent.
- Gap: GAP_CYCLES=5, two-byte message → exactly 7 cycles between tx_done and the next tx_start.
- Timeout: TIMEOUT_CYCLES=16, tx_done never pulses → timeout_err=1 at cycle 16 of WAIT_DONE, grant=00, state IDLE; timeout_err stays set.
- Reset mid-WAIT_DONE: rst_n pulsed low → all outputs to reset values immediately; a fresh req0 byte 0x64 afterwards is transmitted normally.
